// File: rtl/bram_hex_viewer.sv
// bram_hex_viewer
// Walks a block-RAM read port one address at a time and shows either the
// captured read word or the current address as hex on a multiplexed
// common-anode 7-segment display.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   step       one-cycle pulse, advance the address by one
//   auto_en    advance automatically every AUTO_DIV cycles (step still honoured)
//   show_addr  1: show rd_addr, 0: show captured data
//   rd_addr    bram read address (registered)
//   rd_en      bram read enable, one-cycle pulse per read (registered)
//   rd_data    bram read data, valid RD_LATENCY cycles after rd_en
//   busy       high from read issue until the data is captured (registered)
//   an         digit enables, active-low, one-hot-low (registered)
//   sseg       segments {dp,g,f,e,d,c,b,a}, active-low (registered)
module bram_hex_viewer #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int RD_LATENCY  = 2,
    parameter int REFRESH_DIV = 16,
    parameter int AUTO_DIV    = 2**24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  step,
    input  logic                  auto_en,
    input  logic                  show_addr,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_en,
    input  logic [DATA_W-1:0]     rd_data,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] an,
    output logic [7:0]            sseg
);

    localparam int VAL_W       = 4 * NUM_DIGITS;
    localparam int AUTO_W      = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam int PRE_W       = $clog2(REFRESH_DIV);
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ADDR_DIGITS = (ADDR_W + 3) / 4;
    localparam int DATA_DIGITS = (DATA_W + 3) / 4;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    state_t                state_r, state_next_s;
    logic [ADDR_W-1:0]     rd_addr_r;
    logic                  rd_en_r;
    logic                  busy_r;
    logic [DATA_W-1:0]     data_reg_r;
    logic                  pending_r;
    logic [2:0]            wait_cnt_r;
    logic [AUTO_W-1:0]     auto_cnt_r;
    logic                  auto_tick_s;
    logic                  adv_req_s;
    logic [PRE_W-1:0]      prescaler_r;
    logic                  pre_wrap_s;
    logic [IDX_W-1:0]      digit_idx_r;
    logic                  slot_start_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic [7:0]            sseg_r;
    logic [VAL_W-1:0]      value_s;
    logic [3:0]            nibble_s;
    logic [7:0]            seg_s;
    logic [NUM_DIGITS-1:0] onehot_s;
    int                    used_digits_s;

    // Active-low hex glyph with the decimal point off.
    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    assign auto_tick_s = auto_en && (auto_cnt_r == AUTO_W'(AUTO_DIV - 1));
    // step and auto_tick in the same cycle collapse into one advance
    assign adv_req_s   = step | auto_tick_s;
    assign pre_wrap_s  = (prescaler_r == PRE_W'(REFRESH_DIV - 1));

    // Read sequencer next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                state_next_s = ST_ISSUE;
            end
            ST_IDLE: begin
                if (adv_req_s || pending_r) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (RD_LATENCY == 1) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // WAIT spans RD_LATENCY-1 cycles, so CAPTURE lines up with valid data
                if (wait_cnt_r == 3'(RD_LATENCY - 2)) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_CAPTURE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_INIT;
            end
        endcase
    end

    // Read sequencer state, address, strobe, capture and pending request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_INIT;
            rd_addr_r  <= {ADDR_W{1'b0}};
            rd_en_r    <= 1'b0;
            busy_r     <= 1'b0;
            data_reg_r <= {DATA_W{1'b0}};
            pending_r  <= 1'b0;
            wait_cnt_r <= 3'd0;
        end else begin
            state_r <= state_next_s;
            rd_en_r <= (state_next_s == ST_ISSUE);
            busy_r  <= (state_next_s == ST_ISSUE) || (state_next_s == ST_WAIT) ||
                       (state_next_s == ST_CAPTURE);
            if ((state_r == ST_IDLE) && (state_next_s == ST_ISSUE)) begin
                rd_addr_r <= rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 3'd1;
            end else begin
                wait_cnt_r <= 3'd0;
            end
            if (state_r == ST_CAPTURE) begin
                data_reg_r <= rd_data;
            end
            // IDLE always consumes (or has no) pending; elsewhere a request is parked 1-deep
            if (state_r == ST_IDLE) begin
                pending_r <= 1'b0;
            end else if (adv_req_s) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Auto-advance interval counter, held at zero while auto mode is off.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_cnt_r <= {AUTO_W{1'b0}};
        end else if (!auto_en || auto_tick_s) begin
            auto_cnt_r <= {AUTO_W{1'b0}};
        end else begin
            auto_cnt_r <= auto_cnt_r + {{(AUTO_W-1){1'b0}}, 1'b1};
        end
    end

    // Glyph and digit-enable for the digit currently selected by the scan.
    always_comb begin
        value_s = show_addr ? VAL_W'(rd_addr_r) : VAL_W'(data_reg_r);
        nibble_s = value_s[{digit_idx_r, 2'b00} +: 4];
        if (show_addr) begin
            used_digits_s = ADDR_DIGITS;
        end else begin
            used_digits_s = DATA_DIGITS;
        end
        if (int'(digit_idx_r) >= used_digits_s) begin
            seg_s = 8'hFF;
        end else begin
            seg_s    = hex_seg(nibble_s);
            seg_s[7] = ~(auto_en && (digit_idx_r == {IDX_W{1'b0}}));
        end
        onehot_s = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot_s[i] = (digit_idx_r == IDX_W'(i));
        end
    end

    // Digit scan: prescaler, digit index, and a per-slot snapshot of an/sseg.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_r  <= {PRE_W{1'b0}};
            digit_idx_r  <= {IDX_W{1'b0}};
            slot_start_r <= 1'b0;
            an_r         <= {NUM_DIGITS{1'b1}};
            sseg_r       <= 8'hFF;
        end else begin
            slot_start_r <= pre_wrap_s;
            if (pre_wrap_s) begin
                prescaler_r <= {PRE_W{1'b0}};
                if (digit_idx_r == IDX_W'(NUM_DIGITS - 1)) begin
                    digit_idx_r <= {IDX_W{1'b0}};
                end else begin
                    digit_idx_r <= digit_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end else begin
                prescaler_r <= prescaler_r + {{(PRE_W-1){1'b0}}, 1'b1};
            end
            // Loading once per slot keeps the glyph steady and delays show_addr to the next slot
            if (slot_start_r) begin
                an_r   <= ~onehot_s;
                sseg_r <= seg_s;
            end else begin
                an_r   <= an_r;
                sseg_r <= sseg_r;
            end
        end
    end

    assign rd_addr = rd_addr_r;
    assign rd_en   = rd_en_r;
    assign busy    = busy_r;
    assign an      = an_r;
    assign sseg    = sseg_r;

endmodule
